// File: rtl/spi_flash_op_sequencer.sv
// Expands one flash operation into a sequence of SPI controller accesses.
// Define SPI_SEQ_ADDR4_EN for 4-byte addressing and the 4-byte opcode set.
module spi_flash_op_sequencer #(
    parameter int DUMMY_CYCLES = 7,
    parameter int POLL_GAP     = 64,
    parameter int POLL_LIMIT   = 65535
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [1:0]  op_code,
    input  logic [31:0] op_addr,
    input  logic [7:0]  op_len,
    output logic        op_done,
    output logic        op_error,
    output logic        busy,
    output logic        access_request,
    output logic        read_write_n,
    output logic [7:0]  command,
    output logic [31:0] address,
    output logic [1:0]  address_bytes,
    output logic        address_valid,
    output logic [2:0]  dummy_cycles,
    output logic        dummy_valid,
    output logic [7:0]  data_bytes,
    output logic        data_valid,
    input  logic        access_complete,
    input  logic        write_enable,
    input  logic [7:0]  write_address,
    input  logic [7:0]  write_data
);

    localparam int PCW = $clog2(POLL_LIMIT + 1);
    localparam int GCW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    localparam logic [1:0] OP_READ       = 2'd0;
    localparam logic [1:0] OP_PROGRAM    = 2'd1;
    localparam logic [1:0] OP_ERASE      = 2'd2;
    localparam logic [1:0] OP_FAST_READ  = 2'd3;

    localparam logic [7:0] CMD_WREN      = 8'h06;
    localparam logic [7:0] CMD_RDSR      = 8'h05;

`ifdef SPI_SEQ_ADDR4_EN
    localparam logic [7:0] CMD_READ      = 8'h13;
    localparam logic [7:0] CMD_FAST_READ = 8'h0C;
    localparam logic [7:0] CMD_PROGRAM   = 8'h12;
    localparam logic [7:0] CMD_ERASE     = 8'h21;
    localparam logic [1:0] ADDR_BYTES    = 2'd3;
`else
    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;
    localparam logic [7:0] CMD_PROGRAM   = 8'h02;
    localparam logic [7:0] CMD_ERASE     = 8'h20;
    localparam logic [1:0] ADDR_BYTES    = 2'd2;
`endif

    typedef enum logic [2:0] {
        IDLE,
        WREN_REQ,
        OP_REQ,
        POLL_REQ,
        POLL_WAIT,
        DONE
    } state_t;

    typedef struct packed {
        logic        rw_n;
        logic [7:0]  cmd;
        logic [31:0] addr;
        logic [1:0]  addr_bytes;
        logic        addr_v;
        logic [2:0]  dummy;
        logic        dummy_v;
        logic [7:0]  data_bytes;
        logic        data_v;
    } desc_t;

    state_t           state;
    desc_t            desc_q;
    logic [1:0]       code_q;
    logic [31:0]      addr_q;
    logic [7:0]       len_q;
    logic [PCW-1:0]   poll_cnt;
    logic [GCW-1:0]   gap_cnt;
    logic [7:0]       status_q;
    logic [31:0]      addr_map;
    logic             unused_status;
    logic             code_is_read;

`ifdef SPI_SEQ_ADDR4_EN
    assign addr_map = op_addr;
`else
    logic unused_addr_hi;
    assign addr_map = {8'h00, op_addr[23:0]};
    assign unused_addr_hi = ^op_addr[31:24];
`endif

    assign unused_status = ^status_q[7:1];
    assign code_is_read  = (code_q == OP_READ) || (code_q == OP_FAST_READ);

    function automatic desc_t make_desc(
        input state_t      s,
        input logic [1:0]  c,
        input logic [31:0] a,
        input logic [7:0]  n
    );
        desc_t d;
        d = '0;
        case (s)
            WREN_REQ: d.cmd = CMD_WREN;
            OP_REQ: begin
                d.addr_v     = 1'b1;
                d.addr       = a;
                d.addr_bytes = ADDR_BYTES;
                unique case (c)
                    OP_READ: begin
                        d.cmd        = CMD_READ;
                        d.rw_n       = 1'b1;
                        d.data_v     = 1'b1;
                        d.data_bytes = n;
                    end
                    OP_FAST_READ: begin
                        d.cmd        = CMD_FAST_READ;
                        d.rw_n       = 1'b1;
                        d.dummy_v    = 1'b1;
                        d.dummy      = 3'(DUMMY_CYCLES);
                        d.data_v     = 1'b1;
                        d.data_bytes = n;
                    end
                    OP_PROGRAM: begin
                        d.cmd        = CMD_PROGRAM;
                        d.data_v     = 1'b1;
                        d.data_bytes = n;
                    end
                    OP_ERASE: d.cmd = CMD_ERASE;
                endcase
            end
            POLL_REQ: begin
                d.cmd    = CMD_RDSR;
                d.rw_n   = 1'b1;
                d.data_v = 1'b1;
            end
            default: d = '0;
        endcase
        return d;
    endfunction

    assign read_write_n  = desc_q.rw_n;
    assign command       = desc_q.cmd;
    assign address       = desc_q.addr;
    assign address_bytes = desc_q.addr_bytes;
    assign address_valid = desc_q.addr_v;
    assign dummy_cycles  = desc_q.dummy;
    assign dummy_valid   = desc_q.dummy_v;
    assign data_bytes    = desc_q.data_bytes;
    assign data_valid    = desc_q.data_v;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            desc_q         <= '0;
            code_q         <= '0;
            addr_q         <= '0;
            len_q          <= '0;
            poll_cnt       <= '0;
            gap_cnt        <= '0;
            status_q       <= '0;
            op_ready       <= 1'b1;
            busy           <= 1'b0;
            op_done        <= 1'b0;
            op_error       <= 1'b0;
            access_request <= 1'b0;
        end else begin
            op_done  <= 1'b0;
            op_error <= 1'b0;
            if (state == POLL_REQ && write_enable && write_address == 8'h00) begin
                status_q <= write_data;
            end
            unique case (state)
                IDLE: begin
                    if (op_valid && op_ready) begin
                        code_q         <= op_code;
                        addr_q         <= addr_map;
                        len_q          <= op_len;
                        op_ready       <= 1'b0;
                        busy           <= 1'b1;
                        access_request <= 1'b1;
                        if (op_code == OP_PROGRAM || op_code == OP_ERASE) begin
                            state  <= WREN_REQ;
                            desc_q <= make_desc(WREN_REQ, op_code, addr_map, op_len);
                        end else begin
                            state  <= OP_REQ;
                            desc_q <= make_desc(OP_REQ, op_code, addr_map, op_len);
                        end
                    end
                end
                WREN_REQ, OP_REQ, POLL_REQ: begin
                    // A one-cycle request gap separates back-to-back accesses
                    if (!access_request) begin
                        access_request <= 1'b1;
                        desc_q         <= make_desc(state, code_q, addr_q, len_q);
                    end else if (access_complete) begin
                        access_request <= 1'b0;
                        desc_q         <= '0;
                        if (state == WREN_REQ) begin
                            state <= OP_REQ;
                        end else if (state == OP_REQ) begin
                            if (code_is_read) begin
                                state   <= DONE;
                                op_done <= 1'b1;
                            end else begin
                                state    <= POLL_REQ;
                                poll_cnt <= '0;
                            end
                        end else begin
                            poll_cnt <= poll_cnt + PCW'(1);
                            if (!status_q[0]) begin
                                state   <= DONE;
                                op_done <= 1'b1;
                            end else if (poll_cnt + PCW'(1) == PCW'(POLL_LIMIT)) begin
                                state    <= DONE;
                                op_done  <= 1'b1;
                                op_error <= 1'b1;
                            end else begin
                                state   <= POLL_WAIT;
                                gap_cnt <= '0;
                            end
                        end
                    end
                end
                POLL_WAIT: begin
                    if (gap_cnt == GCW'(POLL_GAP - 1)) begin
                        state          <= POLL_REQ;
                        gap_cnt        <= '0;
                        access_request <= 1'b1;
                        desc_q         <= make_desc(POLL_REQ, code_q, addr_q, len_q);
                    end else begin
                        gap_cnt <= gap_cnt + GCW'(1);
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    op_ready <= 1'b1;
                    busy     <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
